// File: rtl/cache_fill_if.sv
// Miss/memory/cache-array signal bundle between the pipeline, memory and the fill controller.
// Latency: none, wires only.
// Backpressure: none; the controller stalls its requester through fsm_busy.
interface cache_fill_if #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_WIDTH      = 16
);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);

    logic                  miss_detected;
    logic [ADDR_WIDTH-1:0] miss_address;
    logic                  memory_data_valid;
    logic [15:0]           memory_data;
    logic                  fsm_busy;
    logic                  mem_read_en;
    logic [ADDR_WIDTH-1:0] memory_address;
    logic                  write_data_array;
    logic [OFF_W-1:0]      cache_word_offset;
    logic [15:0]           cache_data;
    logic                  write_tag_array;
    logic                  fill_done;

    // Pipeline/memory side: raises misses, returns words, observes the fill.
    modport master (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, mem_read_en, memory_address, write_data_array,
        input  cache_word_offset, cache_data, write_tag_array, fill_done
    );

    // Fill controller side.
    modport slave (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, mem_read_en, memory_address, write_data_array,
        output cache_word_offset, cache_data, write_tag_array, fill_done
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one block as WORDS_PER_BLOCK 16-bit reads and writes it into the cache.
// Latency: reads issue from the first FILL cycle, one per cycle; tag write in the cycle the last word returns.
// Backpressure: stalls the requester via fsm_busy; memory is never throttled, and returned words are counted by valid.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic       clk,
    input  logic       rst,
    cache_fill_if.slave bus
);
    localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W = OFF_W + 1;
    localparam int LOW_W = OFF_W + 1;   // byte-offset bits within a block

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CNT_W-1:0]      issue_cnt;
    logic [OFF_W-1:0]      recv_cnt;
    logic [ADDR_WIDTH-1:0] base;

    logic issuing;
    logic receiving;
    logic last_word;

    assign issuing   = (state_q == FILL) && (issue_cnt < CNT_W'(WORDS_PER_BLOCK));
    assign receiving = (state_q == FILL) && bus.memory_data_valid;
    assign last_word = receiving && (recv_cnt == OFF_W'(WORDS_PER_BLOCK - 1));

    // State register plus issue/receive counters and latched block base.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            issue_cnt <= '0;
            recv_cnt  <= '0;
            base      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (bus.miss_detected) begin
                    base      <= {bus.miss_address[ADDR_WIDTH-1:LOW_W], LOW_W'(0)};
                    issue_cnt <= '0;
                    recv_cnt  <= '0;
                end
            end else if (last_word) begin
                issue_cnt <= '0;
                recv_cnt  <= '0;
            end else begin
                if (issuing) begin
                    issue_cnt <= issue_cnt + 1'b1;
                end
                if (receiving) begin
                    recv_cnt <= recv_cnt + 1'b1;
                end
            end
        end
    end

    // Next state: a miss starts a fill; the final returned word ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.miss_detected) state_d = FILL;
            FILL:    if (last_word)         state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: stall, read issue and array writes, all forced low during reset.
    always_comb begin
        bus.fsm_busy          = 1'b0;
        bus.mem_read_en       = 1'b0;
        bus.memory_address    = '0;
        bus.write_data_array  = 1'b0;
        bus.cache_word_offset = '0;
        bus.cache_data        = '0;
        bus.write_tag_array   = 1'b0;
        bus.fill_done         = 1'b0;
        if (!rst) begin
            bus.fsm_busy = (state_q == FILL) || bus.miss_detected;
            if (issuing) begin
                bus.mem_read_en    = 1'b1;
                bus.memory_address = base + (ADDR_WIDTH'(issue_cnt) << 1);
            end
            if (receiving) begin
                bus.write_data_array  = 1'b1;
                bus.cache_word_offset = recv_cnt;
                bus.cache_data        = bus.memory_data;
            end
            if (last_word) begin
                bus.write_tag_array = 1'b1;
                bus.fill_done       = 1'b1;
            end
        end
    end
endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Miss-handling controller placed downstream of the pipeline's memory-access stages, between the I-cache/D-cache arrays and a multi-cycle, pipelined main memory.
- On a cache miss it stalls the requester and fetches one 16-byte block as 8 consecutive 16-bit words.
- It writes each returned word into the cache data array, then writes the tag in the cycle the last word lands.
- One instance per cache; arbitration between the two instances is handled outside this block.

Parameters:
WORDS_PER_BLOCK, 8, 16-bit words per cache block; power of two; block bytes = 2*WORDS_PER_BLOCK.
MEM_LATENCY, 4, nominal memory read latency in cycles; used only for the test plan, the RTL counts valids and does not depend on it.
ADDR_WIDTH, 16, byte address width.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
miss_detected  input  1  cache lookup missed this cycle
miss_address  input  ADDR_WIDTH  byte address of the missing access
memory_data_valid  input  1  memory_data holds a returned word
memory_data  input  16  word returned by memory
fsm_busy  output  1  stall request to the pipeline
mem_read_en  output  1  issue a read to memory this cycle
memory_address  output  ADDR_WIDTH  byte address of the read being issued
write_data_array  output  1  write cache_data into data array this cycle
cache_word_offset  output  log2(WORDS_PER_BLOCK)  word index within the block for the data write
cache_data  output  16  data for the data-array write (equals memory_data)
write_tag_array  output  1  write the tag/valid for the latched block this cycle
fill_done  output  1  one-cycle pulse, fill complete

Behaviour:
- Reset (async, any time, including mid-fill):
  - state=IDLE; issue_cnt=0; recv_cnt=0; base=0.
  - Every output reads 0 while rst is high.
- States:
  - IDLE -> FILL when miss_detected=1. On that edge, base is latched as miss_address with the low log2(2*WORDS_PER_BLOCK) bits cleared.
  - FILL -> IDLE on the edge after the cycle in which the WORDS_PER_BLOCK-th valid is received.
- fsm_busy is combinational: (state==FILL) | (state==IDLE & miss_detected). The pipeline stalls in the same cycle as the miss and releases in the first IDLE cycle.
- Issue side (FILL only):
  - mem_read_en=1 while issue_cnt<WORDS_PER_BLOCK.
  - memory_address = base + 2*issue_cnt; issue_cnt increments each issuing cycle, giving one read per cycle with no gaps.
  - When not issuing: mem_read_en=0 and memory_address=0.
- Receive side (FILL only):
  - On memory_data_valid=1: write_data_array=1, cache_word_offset=recv_cnt, cache_data=memory_data; recv_cnt increments.
  - Valids may arrive with gaps. The block counts valids, not cycles.
- Completion: in the cycle the last word is received (recv_cnt==WORDS_PER_BLOCK-1 and valid=1), write_data_array, write_tag_array and fill_done are all 1. Counters clear on the following edge.
- Nominal timing (MEM_LATENCY=4), with F0 = first FILL cycle:
  - issues in F0..F7;
  - data in F4..F11;
  - tag write and fill_done in F11;
  - IDLE at F12.
- Ignored inputs:
  - miss_detected while in FILL.
  - memory_data_valid while in IDLE: no writes, counters unchanged.
- Back-to-back: a miss asserted in the first IDLE cycle after a fill is accepted immediately.
- Address arithmetic is modulo 2^ADDR_WIDTH. A block at 0xFFF0 issues 0xFFF0..0xFFFE with no carry into other state.
- When no write is happening, cache_word_offset and cache_data are 0.

Test Plan:
- Basic fill: miss_address=0x1234 at cycle 0 -> fsm_busy=1 at cycle 0; memory_address 0x1230,0x1232,...,0x123E in F0..F7; memory returns D0..D7 in F4..F11 -> offsets 0..7 with matching data; write_tag_array and fill_done in F11 only; fsm_busy=0 in F12.
- Gapped return: valids with one idle cycle between each word -> exactly 8 data writes; tag pulse on the 8th valid only; fsm_busy held high throughout.
- Ignored events: second miss (0x4000) mid-fill and a stray valid in IDLE -> no new issues; base stays 0x1230; no data-array writes in IDLE.
- Reset mid-fill: rst pulsed after 3 words received -> all outputs 0 immediately. A new miss at 0x00A6 then fills from 0x00A0 with offsets starting at 0.
- Back-to-back: miss 0xFFF2 asserted in the first IDLE cycle after a fill -> accepted that cycle; addresses 0xFFF0..0xFFFE; no wrap corruption.
